usb_ep_fifo: RTL and testbench
==============================

# usb_ep_fifo

Parametrised endpoint FIFO with packet-level commit, discard and rewind. It generalises the plain single-clock FIFO handshake (data/q/wrreq/rdreq/sclr/empty/full) with tentative write and read pointers. The SIE-side writer can drop a packet on rx_error, and the reader can replay a packet after a missing handshake. It sits between the SIE and the CPU-side io registers, one instance per endpoint direction.

## Interface
- addr_width, 4: memory address bits; depth D = 2**addr_width words.
- data_width, 8: word width.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sclr  in  1  synchronous clear; same effect as reset except q is held.
- data  in  data_width  write data.
- wrreq  in  1  write request.
- wr_commit  in  1  make all tentatively written words, including this cycle's, visible to the reader.
- wr_discard  in  1  drop all uncommitted words, including this cycle's.
- q  out  data_width  read data, registered.
- rdreq  in  1  read request.
- rd_commit  in  1  release all words read so far, including this cycle's, back to the writer.
- rd_rewind  in  1  rewind the read pointer to the last rd_commit point.
- empty  out  1  no committed unread word.
- full  out  1  no free slot; unreleased words count as occupied.
- rd_avail  out  addr_width+1  committed words not yet read.
- wr_free  out  addr_width+1  free slots.
- overflow  out  1  sticky: wrreq while full.
- underflow  out  1  sticky: rdreq while empty.

## Operation
- Pointers are addr_width+1 bits and wrap modulo 2·D: wr_ptr (tentative), wr_base (committed), rd_ptr (tentative), rd_base (released).
- Derived values:
  - empty = (rd_ptr == wr_base)
  - full = (wr_ptr − rd_base == D)
  - rd_avail = wr_base − rd_ptr
  - wr_free = D − (wr_ptr − rd_base)
  - All are computed combinationally from registered pointers only.
- Write: wrreq & !full → mem[wr_ptr] ← data, wr_ptr+1. wrreq & full → write ignored, overflow ← 1.
- wr_commit: wr_base ← next wr_ptr, counting this cycle's accepted write.
- wr_discard: wr_ptr ← wr_base, and this cycle's write is dropped. wr_discard has priority over wr_commit.
- Read: rdreq & !empty & !rd_rewind → q ← mem[rd_ptr], rd_ptr+1. rdreq & empty → ignored, q held, underflow ← 1.
- rd_commit: rd_base ← next rd_ptr, counting this cycle's read.
- rd_rewind: rd_ptr ← rd_base. rdreq in the same cycle is ignored, with no underflow. rd_rewind has priority over rd_commit.
- Priority, highest first: reset > sclr > all other inputs.
  - reset: all pointers 0, flags 0, q 0.
  - sclr: all pointers 0, flags 0, q held.
- overflow/underflow clear only on reset or sclr.

## Timing
- Reset values: q=0, empty=1, full=0, rd_avail=0, wr_free=D, overflow=0, underflow=0.
- Read latency: rdreq sampled at edge N → new q valid after edge N; q is stable until the next accepted read.
- Write-to-read: a word committed at edge N drops empty after edge N and can be read at edge N+1 at the earliest.
- Release: a word released by rd_commit at edge N raises wr_free and drops full after edge N.
- Flags and counts are registered-pointer based; there is no combinational path from wrreq/rdreq to empty/full.
- Sustained throughput: one write and one read per cycle when neither flag blocks.
- Simultaneous wrreq and rdreq at the same address are legal only after commit, so no read-during-write hazard is possible. The memory may use write-first or read-first ordering.
- Reset or sclr mid-packet: all uncommitted and unreleased data is lost with no flags raised.

## Test plan
- Write 5 words 0x11..0x15 with wr_commit on the 5th → empty falls the next cycle, rd_avail=5. Read 5 with rd_commit on the last → q sequence 0x11..0x15, then empty=1 and wr_free=16.
- Write 3 words, assert wr_discard with the 4th wrreq → rd_avail stays 0, wr_free=16, empty stays 1.
- Commit 4 words 0xA0..0xA3, read all 4 without rd_commit, pulse rd_rewind, read 4 again → q repeats 0xA0..0xA3. Then rd_commit → wr_free=16.
- Write and commit 16 words, read 16 without rd_commit → full stays 1. A further wrreq sets overflow and memory is unchanged. rd_commit → full=0 the next cycle.
- rdreq while empty → underflow=1 and q unchanged. Assert sclr → underflow=0, empty=1, q still unchanged.
- wrreq+wr_commit and rdreq+rd_commit every cycle in steady state for 40 cycles (crossing pointer wrap) → data order preserved, no flags set.

Source files
------------

// File: rtl/usb_ep_fifo.sv
// Endpoint FIFO with packet-level write commit/discard and read commit/rewind.
// Tentative pointers run ahead of committed/released bases; flags derive from registered pointers only.
module usb_ep_fifo #(
  parameter int addr_width = 4,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclr,
  input  logic [data_width-1:0] data,
  input  logic                  wrreq,
  input  logic                  wr_commit,
  input  logic                  wr_discard,
  output logic [data_width-1:0] q,
  input  logic                  rdreq,
  input  logic                  rd_commit,
  input  logic                  rd_rewind,
  output logic                  empty,
  output logic                  full,
  output logic [addr_width:0]   rd_avail,
  output logic [addr_width:0]   wr_free,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << addr_width;
  localparam logic [addr_width:0] W_DEPTH = (addr_width+1)'(DEPTH);

  logic [data_width-1:0] r_mem [DEPTH];

  logic [addr_width:0] r_wr_ptr;
  logic [addr_width:0] r_wr_base;
  logic [addr_width:0] r_rd_ptr;
  logic [addr_width:0] r_rd_base;
  logic                r_overflow;
  logic                r_underflow;
  logic [data_width-1:0] r_q;

  logic [addr_width:0] w_used;
  logic                w_empty;
  logic                w_full;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [addr_width:0] w_wr_ptr_nxt;
  logic [addr_width:0] w_rd_ptr_nxt;

  assign w_used  = r_wr_ptr - r_rd_base;
  assign w_empty = (r_rd_ptr == r_wr_base);
  assign w_full  = (w_used == W_DEPTH);

  assign w_wr_acc = wrreq & ~w_full;
  assign w_rd_acc = rdreq & ~w_empty & ~rd_rewind;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    if (wr_discard)
      w_wr_ptr_nxt = r_wr_base;
    else if (w_wr_acc)
      w_wr_ptr_nxt = r_wr_ptr + 1'b1;
  end

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if (rd_rewind)
      w_rd_ptr_nxt = r_rd_base;
    else if (w_rd_acc)
      w_rd_ptr_nxt = r_rd_ptr + 1'b1;
  end

  // A discarded write may land in an uncommitted slot; it is never visible.
  always_ff @(posedge clk) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr[addr_width-1:0]] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_wr_base   <= '0;
      r_rd_ptr    <= '0;
      r_rd_base   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_q         <= '0;
    end else if (sclr) begin
      r_wr_ptr    <= '0;
      r_wr_base   <= '0;
      r_rd_ptr    <= '0;
      r_rd_base   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      if (wr_commit && !wr_discard)
        r_wr_base <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      if (rd_commit && !rd_rewind)
        r_rd_base <= w_rd_ptr_nxt;
      if (w_rd_acc)
        r_q <= r_mem[r_rd_ptr[addr_width-1:0]];
      if (wrreq && w_full)
        r_overflow <= 1'b1;
      if (rdreq && w_empty && !rd_rewind)
        r_underflow <= 1'b1;
    end
  end

  assign q         = r_q;
  assign empty     = w_empty;
  assign full      = w_full;
  assign rd_avail  = r_wr_base - r_rd_ptr;
  assign wr_free   = W_DEPTH - w_used;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_usb_ep_fifo.sv
// Scoreboard bench for usb_ep_fifo: expected read data is queued as reads are driven
// and compared when q updates; flags and counts are checked against constants.
module tb_usb_ep_fifo;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, sclr;
  logic [DW-1:0] data;
  logic          wrreq, wr_commit, wr_discard;
  logic [DW-1:0] q;
  logic          rdreq, rd_commit, rd_rewind;
  logic          empty, full;
  logic [AW:0]   rd_avail, wr_free;
  logic          overflow, underflow;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [DW-1:0] exp_q[$];

  usb_ep_fifo #(.addr_width(AW), .data_width(DW)) dut (
    .clk(clk), .reset(reset), .sclr(sclr),
    .data(data), .wrreq(wrreq), .wr_commit(wr_commit), .wr_discard(wr_discard),
    .q(q), .rdreq(rdreq), .rd_commit(rd_commit), .rd_rewind(rd_rewind),
    .empty(empty), .full(full), .rd_avail(rd_avail), .wr_free(wr_free),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; sclr = 0; data = '0; wrreq = 0; wr_commit = 0; wr_discard = 0;
    rdreq = 0; rd_commit = 0; rd_rewind = 0;
  endtask

  // Drive one accepted read (expected value queued now), clock, compare q.
  task automatic rd_step(input logic [DW-1:0] e, input logic commit);
    rdreq = 1; rd_commit = commit;
    exp_q.push_back(e);
    cyc();
    rdreq = 0; rd_commit = 0;
    if (exp_q.size() == 0) check("sb_underrun", 1, 0);
    else check("rd_data", {24'h0, q}, {24'h0, exp_q.pop_front()});
  endtask

  task automatic wr_step(input logic [DW-1:0] d, input logic commit);
    wrreq = 1; data = d; wr_commit = commit;
    cyc();
    wrreq = 0; wr_commit = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    cyc(); cyc();
    reset = 0;
    check("rst_q", {24'h0, q}, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_avail", rd_avail, 0);
    check("rst_wr_free", wr_free, 16);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);

    // Packet of 5 committed on the last word
    for (int i = 0; i < 5; i++) begin
      wr_step(8'h11 + 8'(i), i == 4);
      if (i == 3) check("pre_commit_empty", empty, 1);
    end
    check("commit_empty", empty, 0);
    check("commit_rd_avail", rd_avail, 5);
    check("commit_wr_free", wr_free, 11);
    for (int i = 0; i < 5; i++) rd_step(8'h11 + 8'(i), i == 4);
    check("drain_empty", empty, 1);
    check("drain_wr_free", wr_free, 16);
    check("drain_rd_avail", rd_avail, 0);

    // Discard: 3 writes then discard together with the 4th
    for (int i = 0; i < 3; i++) wr_step(8'h60 + 8'(i), 0);
    check("tent_wr_free", wr_free, 13);
    check("tent_empty", empty, 1);
    wr_discard = 1;
    wr_step(8'h63, 1);
    wr_discard = 0;
    check("disc_rd_avail", rd_avail, 0);
    check("disc_wr_free", wr_free, 16);
    check("disc_empty", empty, 1);

    // Rewind replay
    for (int i = 0; i < 4; i++) wr_step(8'hA0 + 8'(i), i == 3);
    for (int i = 0; i < 4; i++) rd_step(8'hA0 + 8'(i), 0);
    check("rw_wr_free_unrel", wr_free, 12);
    rd_rewind = 1; rdreq = 1;
    cyc();
    rd_rewind = 0; rdreq = 0;
    check("rw_no_udf", underflow, 0);
    check("rw_q_held", {24'h0, q}, 32'hA3);
    check("rw_rd_avail", rd_avail, 4);
    for (int i = 0; i < 4; i++) rd_step(8'hA0 + 8'(i), i == 3);
    check("rw_wr_free", wr_free, 16);

    // Full boundary and overflow
    for (int i = 0; i < 16; i++) wr_step(8'h30 + 8'(i), i == 15);
    check("full_set", full, 1);
    check("full_wr_free", wr_free, 0);
    check("full_rd_avail", rd_avail, 16);
    for (int i = 0; i < 16; i++) rd_step(8'h30 + 8'(i), 0);
    check("full_unrel", full, 1);
    check("full_empty", empty, 1);
    wr_step(8'hEE, 1);
    check("ovf_set", overflow, 1);
    check("ovf_rd_avail", rd_avail, 0);
    rd_rewind = 1;
    cyc();
    rd_rewind = 0;
    for (int i = 0; i < 16; i++) rd_step(8'h30 + 8'(i), i == 15);
    check("rel_full", full, 0);
    check("rel_wr_free", wr_free, 16);
    check("ovf_sticky", overflow, 1);

    // Underflow and sclr
    rdreq = 1;
    cyc();
    rdreq = 0;
    check("udf_set", underflow, 1);
    check("udf_q_held", {24'h0, q}, 32'h3F);
    wr_step(8'h77, 0);
    wr_step(8'h78, 0);
    sclr = 1;
    cyc();
    sclr = 0;
    check("sclr_udf", underflow, 0);
    check("sclr_ovf", overflow, 0);
    check("sclr_empty", empty, 1);
    check("sclr_wr_free", wr_free, 16);
    check("sclr_q_held", {24'h0, q}, 32'h3F);

    // Steady state: write+commit and read+commit each cycle, crossing pointer wrap
    wr_step(8'h50, 1);
    for (int k = 1; k < 40; k++) begin
      wrreq = 1; data = 8'h50 + 8'(k); wr_commit = 1;
      rd_step(8'h50 + 8'(k - 1), 1);
      wrreq = 0; wr_commit = 0;
      check("ss_empty", empty, 0);
      check("ss_full", full, 0);
      check("ss_rd_avail", rd_avail, 1);
    end
    rd_step(8'h50 + 8'd39, 1);
    check("ss_end_empty", empty, 1);
    check("ss_end_wr_free", wr_free, 16);
    check("ss_ovf", overflow, 0);
    check("ss_udf", underflow, 0);
    check("sb_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
